// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch unit bus: PC/control inputs, instruction memory port
// and the instruction register handed to decode.
// master = the fetch unit itself, slave = its surroundings (PC, memory, decode).
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_in;
  logic               fetch_en;
  logic               flush;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_req;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ready;
  logic [INSTR_W-1:0] ir_out;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               ir_ack;
  logic               pc_adv;
  logic               fault;

  modport master (
    input  pc_in, fetch_en, flush, mem_rdata, mem_ready, ir_ack,
    output mem_addr, mem_req, ir_out, ir_pc, ir_valid, pc_adv, fault
  );

  modport slave (
    output pc_in, fetch_en, flush, mem_rdata, mem_ready, ir_ack,
    input  mem_addr, mem_req, ir_out, ir_pc, ir_valid, pc_adv, fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one memory read per fetch, holds the
// returned word in an instruction register until decode acknowledges it,
// and raises a sticky fault on a memory timeout.
// Optional: define IFU_MISALIGN_TRAP_EN to fault on a PC with nonzero low
// bits instead of silently aligning it down to a word boundary.
module instruction_fetch_unit #(
  parameter int ADDR_W   = 64,
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 15
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] ir_out_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               pc_adv_q;
  logic               fault_q;
  logic [7:0]         wait_cnt_q;
  logic [7:0]         wait_inc;
  logic               misaligned;
  logic               want_fetch;
  logic               launch;
  logic               trap;
  logic               timeout;
  logic               mem_req_c;
  logic               ir_valid_c;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned = (bus.pc_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A fetch is attempted from IDLE (when not faulted) or back-to-back when
  // decode consumes the held instruction; flush suppresses both.
  assign want_fetch = !bus.flush && bus.fetch_en &&
                      (((state_q == IDLE) && !fault_q) ||
                       ((state_q == HOLD) && bus.ir_ack));
  assign launch     = want_fetch && !misaligned;
  assign trap       = want_fetch && misaligned;
  assign wait_inc   = wait_cnt_q + 8'd1;
  assign timeout    = (state_q == REQ) && !bus.mem_ready && (wait_inc == 8'(MAX_WAIT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every other condition.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (launch) state_d = REQ;
        REQ:     if (bus.mem_ready) state_d = HOLD;
                 else if (timeout)  state_d = IDLE;
        HOLD:    if (bus.ir_ack) state_d = launch ? REQ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs follow the state directly, so reset drops them at once.
  always_comb begin
    mem_req_c  = 1'b0;
    ir_valid_c = 1'b0;
    case (state_q)
      REQ:     mem_req_c  = 1'b1;
      HOLD:    ir_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Address, instruction register, wait counter, advance pulse and fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      ir_out_q   <= '0;
      ir_pc_q    <= '0;
      pc_adv_q   <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      pc_adv_q <= 1'b0;
      if (bus.flush) begin
        wait_cnt_q <= '0;
        fault_q    <= 1'b0;
      end else begin
        if (launch) begin
          mem_addr_q <= {bus.pc_in[ADDR_W-1:2], 2'b00};
          wait_cnt_q <= '0;
        end
        if (trap) fault_q <= 1'b1;
        if (state_q == REQ) begin
          if (bus.mem_ready) begin
            ir_out_q <= bus.mem_rdata;
            ir_pc_q  <= mem_addr_q;
            pc_adv_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_inc;
            if (timeout) fault_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_req  = mem_req_c;
  assign bus.ir_out   = ir_out_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_c;
  assign bus.pc_adv   = pc_adv_q;
  assign bus.fault    = fault_q;

endmodule
